maze_walker: RTL and testbench
==============================

# maze_walker

Parametrised wall-following maze solver, successor to the fixed 64x64 right-hand solver. It drives the maze memory's read/write port (`row`, `col`, `maze_oe`, `maze_we`, `maze_in`) and marks every visited cell. It adds the following:

- configurable maze size and follow hand;
- start/busy handshake and restart;
- selectable start direction;
- step counter with a give-up limit (`fail`);
- asynchronous active-low reset.

## Interface
- `ADDR_W`, 6: coordinate width; maze is 2^ADDR_W x 2^ADDR_W, border index `MAXC` = 2^ADDR_W-1.
- `HAND`, 0: 0 = right-hand rule, 1 = left-hand rule.
- `STEP_W`, 16: width of `steps`.
- `MAX_STEPS`, 4095: moves allowed before `fail`; must be < 2^STEP_W.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request; accepted only when `busy`=0.
- `starting_row`, `starting_col`  in  ADDR_W each  start cell, sampled on the accepted `start`.
- `start_dir`  in  2  initial heading: 0 up (row-1), 1 right (col+1), 2 down (row+1), 3 left (col-1).
- `maze_in`  in  1  cell content at the last read address (1 wall, 0 free).
- `row`, `col`  out  ADDR_W each  memory address.
- `maze_oe`  out  1  read enable, one cycle per probe.
- `maze_we`  out  1  write (mark) enable, one cycle per visited cell.
- `busy`  out  1  solver running.
- `done`  out  1  exit reached; sticky.
- `fail`  out  1  step limit hit; sticky.
- `steps`  out  STEP_W  moves made in the current run.

## Operation
- State: `pos_r`, `pos_c` and `dir` (2-bit, mod 4).
  - Side direction: `sd` = `dir`+1 when `HAND`=0, `dir`-1 when `HAND`=1.
  - Opposite side: `dir`+2.
- **IDLE**: `busy`=0, all enables low.
  - On `start`: latch start cell and `start_dir`; clear `steps`, `done`, `fail`; go to MARK.
- **MARK**: `row`/`col` = pos, `maze_we`=1.
  - If pos is on the border (row or col equal to 0 or `MAXC`), go to DONE.
  - Otherwise go to PROBE_S.
- **PROBE_S**: address = pos + step(`sd`), `maze_oe`=1; then WAIT_S.
- **WAIT_S**: sample `maze_in`.
  - 0 (free): if `steps`==`MAX_STEPS`, go to FAIL. Otherwise `dir`<=`sd`, pos<=probed cell, `steps`++, go to MARK.
  - 1 (wall): go to PROBE_F.
- **PROBE_F**: address = pos + step(`dir`), `maze_oe`=1; then WAIT_F.
- **WAIT_F**: sample `maze_in`.
  - 0 (free): same limit check; otherwise pos<=forward cell, `steps`++, go to MARK.
  - 1 (wall): `dir`<=`dir`+2 (180 degree turn), go to PROBE_S.
- **DONE**: `done`=1, `busy`=0. `row`/`col` hold the exit cell.
- **FAIL**: `fail`=1, `busy`=0. `row`/`col` hold the last cell.
- DONE and FAIL both accept a new `start`, which clears both flags.
- `busy`=1 in every state other than IDLE, DONE and FAIL. `start` is ignored while `busy`=1.
- Coordinate arithmetic is ADDR_W-bit. A probe is issued only from an interior cell, so a neighbour address never wraps.
- Visited marks are written unconditionally. The solver ignores marks when routing: a marked cell reads as free, since the memory returns walls only.
- Start cell on the border: MARK then DONE, with `steps`=0.

## Timing
- Reset values: `row`=0, `col`=0, `maze_oe`=0, `maze_we`=0, `busy`=0, `done`=0, `fail`=0, `steps`=0; state IDLE.
- Reset mid-run aborts immediately. No further enables are driven and memory contents are left as they are.
- Outputs are Moore, decoded from registered state, pos and `dir`.
- Memory contract: `maze_oe` high in cycle N; `maze_in` valid in cycle N+1, sampled at the edge ending N+1.
- Cycle counts:
  - `start` accepted at edge E: MARK in cycle E+1, first `maze_we` there.
  - Side-open move: 3 cycles (MARK, PROBE_S, WAIT_S).
  - Side-blocked, forward-open move: 5 cycles.
  - Dead-end turn: adds 4 cycles before the next probe.
- `done`/`fail` rise in the cycle after the deciding MARK or WAIT and stay high until the next accepted `start` or reset.
- `maze_oe` and `maze_we` are never high in the same cycle.

## Test plan
- **Start on border**: start (0,5), `start_dir`=1 -> one `maze_we` at (0,5); `done`=1 two cycles after `start`; `steps`=0; no `maze_oe`.
- **Straight corridor**: walls everywhere except row 10, cols 10..63; start (10,10), dir 1, `HAND`=0 -> 53 forward moves; `done` with `row`=10, `col`=63; `steps`=53; every cell marked once.
- **Dead end**: corridor (10,10)-(10,12) closed at col 13, open exit at (9,10)->(0,10) -> after 2 moves the solver reverses; `done` at (0,10); `steps`=14.
  - Also check the 180-degree turn ordering: PROBE_S then PROBE_F then PROBE_S.
- **Step limit**: closed 4x4 loop, `MAX_STEPS`=20 -> `fail`=1 after exactly 20 moves; `done`=0; `steps`=20; a fresh `start` clears `fail`.
- **Hand parameter**: T-junction at (20,20), left branch exits at col 0, right branch at col 63 -> `HAND`=0 exits at col 63, `HAND`=1 at col 0.
- **Reset mid-run**: assert `rst_n`=0 while in WAIT_F -> all outputs read their reset values within the same cycle; `start` while `busy`=1 during a run -> ignored, no restart.

Source files
------------

// File: rtl/maze_walker.sv
// Wall-following maze solver: walks a 2^ADDR_W square maze through a single
// read/write memory port, marking each visited cell until it reaches the border.
module maze_walker #(
    parameter int ADDR_W    = 6,
    parameter int HAND      = 0,
    parameter int STEP_W    = 16,
    parameter int MAX_STEPS = 4095
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] starting_row,
    input  logic [ADDR_W-1:0] starting_col,
    input  logic [1:0]        start_dir,
    input  logic              maze_in,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] col,
    output logic              maze_oe,
    output logic              maze_we,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [STEP_W-1:0] steps
);

    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] MAXC = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_MARK, S_PROBE_S, S_WAIT_S, S_PROBE_F, S_WAIT_F, S_DONE, S_FAIL
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pos_r_q, pos_r_d;
    logic [ADDR_W-1:0] pos_c_q, pos_c_d;
    logic [1:0]        dir_q, dir_d;
    logic [STEP_W-1:0] steps_q, steps_d;

    logic [1:0]          sd;
    logic [2*ADDR_W-1:0] probe_s, probe_f;
    logic                on_border, at_limit;

    // Neighbour of (r,c) one step along heading d, packed as {row, col}.
    function automatic logic [2*ADDR_W-1:0] nbr(input logic [ADDR_W-1:0] r,
                                                input logic [ADDR_W-1:0] c,
                                                input logic [1:0]        d);
        logic [ADDR_W-1:0] nr, nc;
        nr = r;
        nc = c;
        case (d)
            2'd0:    nr = r - ONE;
            2'd1:    nc = c + ONE;
            2'd2:    nr = r + ONE;
            default: nc = c - ONE;
        endcase
        return {nr, nc};
    endfunction

    assign sd        = (HAND == 0) ? dir_q + 2'd1 : dir_q - 2'd1;
    assign probe_s   = nbr(pos_r_q, pos_c_q, sd);
    assign probe_f   = nbr(pos_r_q, pos_c_q, dir_q);
    assign on_border = (pos_r_q == '0) || (pos_r_q == MAXC) ||
                       (pos_c_q == '0) || (pos_c_q == MAXC);
    assign at_limit  = (steps_q == STEP_W'(MAX_STEPS));

    always_comb begin
        state_d = state_q;
        pos_r_d = pos_r_q;
        pos_c_d = pos_c_q;
        dir_d   = dir_q;
        steps_d = steps_q;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    state_d = S_MARK;
                    pos_r_d = starting_row;
                    pos_c_d = starting_col;
                    dir_d   = start_dir;
                    steps_d = '0;
                end
            end
            S_MARK:    state_d = on_border ? S_DONE : S_PROBE_S;
            S_PROBE_S: state_d = S_WAIT_S;
            S_WAIT_S: begin
                if (maze_in) begin
                    state_d = S_PROBE_F;
                end else if (at_limit) begin
                    state_d = S_FAIL;
                end else begin
                    dir_d              = sd;
                    {pos_r_d, pos_c_d} = probe_s;
                    steps_d            = steps_q + STEP_W'(1);
                    state_d            = S_MARK;
                end
            end
            S_PROBE_F: state_d = S_WAIT_F;
            S_WAIT_F: begin
                if (maze_in) begin
                    // dead end: reverse and retry the side first
                    dir_d   = dir_q + 2'd2;
                    state_d = S_PROBE_S;
                end else if (at_limit) begin
                    state_d = S_FAIL;
                end else begin
                    {pos_r_d, pos_c_d} = probe_f;
                    steps_d            = steps_q + STEP_W'(1);
                    state_d            = S_MARK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pos_r_q <= '0;
            pos_c_q <= '0;
            dir_q   <= '0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            pos_r_q <= pos_r_d;
            pos_c_q <= pos_c_d;
            dir_q   <= dir_d;
            steps_q <= steps_d;
        end
    end

    // Address is held through the wait cycle so the read data matches it.
    always_comb begin
        row     = pos_r_q;
        col     = pos_c_q;
        maze_oe = 1'b0;
        maze_we = 1'b0;
        case (state_q)
            S_MARK:              maze_we = 1'b1;
            S_PROBE_S, S_WAIT_S: begin
                {row, col} = probe_s;
                maze_oe    = (state_q == S_PROBE_S);
            end
            S_PROBE_F, S_WAIT_F: begin
                {row, col} = probe_f;
                maze_oe    = (state_q == S_PROBE_F);
            end
            default: ;
        endcase
    end

    assign busy  = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL));
    assign done  = (state_q == S_DONE);
    assign fail  = (state_q == S_FAIL);
    assign steps = steps_q;

endmodule

// File: tb/tb_maze_walker.sv
// Directed bench for maze_walker: three instances (right hand, left hand,
// short step limit) sharing one maze image with a registered read port each.
module tb_maze_walker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_w [3];
    logic [5:0] srow = '0, scol = '0;
    logic [1:0] sdir = '0;
    logic       rd_w [3];
    logic [5:0] row_w [3];
    logic [5:0] col_w [3];
    logic       oe_w [3], we_w [3], busy_w [3], done_w [3], fail_w [3];
    logic [15:0] steps_w [3];

    bit   maze [0:63][0:63];
    int   marks [0:63][0:63];
    logic [11:0] probes [$];
    int   overlap = 0;
    int   n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    maze_walker #(.ADDR_W(6), .HAND(0), .STEP_W(16), .MAX_STEPS(4095)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_w[0]), .starting_row(srow),
        .starting_col(scol), .start_dir(sdir), .maze_in(rd_w[0]),
        .row(row_w[0]), .col(col_w[0]), .maze_oe(oe_w[0]), .maze_we(we_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .fail(fail_w[0]), .steps(steps_w[0]));
    maze_walker #(.ADDR_W(6), .HAND(1), .STEP_W(16), .MAX_STEPS(4095)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_w[1]), .starting_row(srow),
        .starting_col(scol), .start_dir(sdir), .maze_in(rd_w[1]),
        .row(row_w[1]), .col(col_w[1]), .maze_oe(oe_w[1]), .maze_we(we_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .fail(fail_w[1]), .steps(steps_w[1]));
    maze_walker #(.ADDR_W(6), .HAND(0), .STEP_W(16), .MAX_STEPS(20)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_w[2]), .starting_row(srow),
        .starting_col(scol), .start_dir(sdir), .maze_in(rd_w[2]),
        .row(row_w[2]), .col(col_w[2]), .maze_oe(oe_w[2]), .maze_we(we_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .fail(fail_w[2]), .steps(steps_w[2]));

    // Read data appears the cycle after maze_oe.
    always @(posedge clk)
        for (int i = 0; i < 3; i++)
            if (oe_w[i]) rd_w[i] <= maze[row_w[i]][col_w[i]];

    task automatic all_walls();
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) maze[r][c] = 1'b1;
    endtask

    task automatic clr_log();
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) marks[r][c] = 0;
        probes.delete();
    endtask

    // Call at a negedge: drives start for the following rising edge.
    task automatic kick(input int sel, input logic [5:0] r, input logic [5:0] c,
                        input logic [1:0] d);
        srow = r; scol = c; sdir = d;
        start_w[sel] = 1'b1;
    endtask

    task automatic run(input int sel, input int bound, output int cyc, output bit to);
        to  = 1'b1;
        cyc = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            start_w[sel] = 1'b0;
            cyc++;
            if (oe_w[sel] && we_w[sel]) overlap++;
            if (we_w[sel]) marks[row_w[sel]][col_w[sel]]++;
            if (oe_w[sel]) probes.push_back({row_w[sel], col_w[sel]});
            if (done_w[sel] || fail_w[sel]) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({row_w[0], col_w[0], oe_w[0], we_w[0], busy_w[0], done_w[0], fail_w[0], steps_w[0]} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got r=%0d c=%0d oe=%b we=%b busy=%b done=%b fail=%b steps=%0d want all 0",
                     row_w[0], col_w[0], oe_w[0], we_w[0], busy_w[0], done_w[0], fail_w[0], steps_w[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy_w[0] !== 1'b0 || oe_w[0] !== 1'b0 || we_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b oe=%b we=%b want 0 0 0", busy_w[0], oe_w[0], we_w[0]);
        end
    endtask

    task automatic test_border_start();
        int cyc; bit to;
        all_walls(); clr_log();
        kick(0, 6'd0, 6'd5, 2'd1);
        run(0, 50, cyc, to);
        n_tests++;
        if (to || cyc != 2) begin
            n_fail++;
            $display("FAIL border_done_latency: got cyc=%0d timeout=%b want 2", cyc, to);
        end
        n_tests++;
        if (marks[0][5] != 1 || probes.size() != 0 || steps_w[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL border_marks: mark(0,5)=%0d probes=%0d steps=%0d want 1 0 0",
                     marks[0][5], probes.size(), steps_w[0]);
        end
    endtask

    task automatic test_corridor();
        int cyc, bad; bit to;
        all_walls(); clr_log();
        for (int c = 10; c < 64; c++) maze[10][c] = 1'b0;
        kick(0, 6'd10, 6'd10, 2'd1);
        run(0, 2000, cyc, to);
        n_tests++;
        if (to || cyc != 267) begin
            n_fail++;
            $display("FAIL corridor_cycles: got %0d timeout=%b want 267", cyc, to);
        end
        n_tests++;
        if (row_w[0] !== 6'd10 || col_w[0] !== 6'd63 || steps_w[0] !== 16'd53) begin
            n_fail++;
            $display("FAIL corridor_exit: got (%0d,%0d) steps=%0d want (10,63) 53", row_w[0], col_w[0], steps_w[0]);
        end
        bad = 0;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                if (marks[r][c] != ((r == 10 && c >= 10) ? 1 : 0)) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL corridor_marks: got %0d wrong cells want 0", bad);
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if (done_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || col_w[0] !== 6'd63) begin
            n_fail++;
            $display("FAIL done_sticky: done=%b busy=%b col=%0d want 1 0 63", done_w[0], busy_w[0], col_w[0]);
        end
    endtask

    task automatic test_dead_end();
        int cyc; bit to;
        all_walls(); clr_log();
        for (int c = 10; c <= 12; c++) maze[10][c] = 1'b0;
        for (int r = 0; r < 10; r++) maze[r][10] = 1'b0;
        kick(0, 6'd10, 6'd10, 2'd1);
        run(0, 2000, cyc, to);
        n_tests++;
        if (to || row_w[0] !== 6'd0 || col_w[0] !== 6'd10 || steps_w[0] !== 16'd14) begin
            n_fail++;
            $display("FAIL dead_end_exit: got (%0d,%0d) steps=%0d timeout=%b want (0,10) 14",
                     row_w[0], col_w[0], steps_w[0], to);
        end
        n_tests++;
        if (probes.size() < 8 || probes[4] !== {6'd11, 6'd12} || probes[5] !== {6'd10, 6'd13} ||
            probes[6] !== {6'd9, 6'd12} || probes[7] !== {6'd10, 6'd11}) begin
            n_fail++;
            $display("FAIL turn_order: got probes[4..7]=%h %h %h %h want 2cc 28d 24c 28b",
                     probes.size() > 4 ? probes[4] : 12'h0, probes.size() > 5 ? probes[5] : 12'h0,
                     probes.size() > 6 ? probes[6] : 12'h0, probes.size() > 7 ? probes[7] : 12'h0);
        end
    endtask

    task automatic test_step_limit();
        int cyc; bit to;
        all_walls(); clr_log();
        for (int i = 30; i <= 33; i++) begin
            maze[30][i] = 1'b0; maze[33][i] = 1'b0;
            maze[i][30] = 1'b0; maze[i][33] = 1'b0;
        end
        kick(2, 6'd30, 6'd30, 2'd1);
        run(2, 2000, cyc, to);
        n_tests++;
        if (to || fail_w[2] !== 1'b1 || done_w[2] !== 1'b0 || steps_w[2] !== 16'd20) begin
            n_fail++;
            $display("FAIL step_limit: fail=%b done=%b steps=%0d timeout=%b want 1 0 20",
                     fail_w[2], done_w[2], steps_w[2], to);
        end
        n_tests++;
        if (row_w[2] !== 6'd31 || col_w[2] !== 6'd33 || busy_w[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL fail_pos: got (%0d,%0d) busy=%b want (31,33) 0", row_w[2], col_w[2], busy_w[2]);
        end
        kick(2, 6'd30, 6'd30, 2'd1);
        @(negedge clk);
        start_w[2] = 1'b0;
        n_tests++;
        if (fail_w[2] !== 1'b0 || busy_w[2] !== 1'b1 || steps_w[2] !== 16'd0 || we_w[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clears: fail=%b busy=%b steps=%0d we=%b want 0 1 0 1",
                     fail_w[2], busy_w[2], steps_w[2], we_w[2]);
        end
        run(2, 2000, cyc, to);
    endtask

    task automatic test_hand();
        int cyc; bit to;
        all_walls(); clr_log();
        for (int c = 0; c < 64; c++) maze[20][c] = 1'b0;
        for (int r = 21; r <= 25; r++) maze[r][20] = 1'b0;
        kick(0, 6'd25, 6'd20, 2'd0);
        run(0, 2000, cyc, to);
        n_tests++;
        if (to || row_w[0] !== 6'd20 || col_w[0] !== 6'd63 || steps_w[0] !== 16'd48) begin
            n_fail++;
            $display("FAIL hand_right: got (%0d,%0d) steps=%0d timeout=%b want (20,63) 48",
                     row_w[0], col_w[0], steps_w[0], to);
        end
        kick(1, 6'd25, 6'd20, 2'd0);
        run(1, 2000, cyc, to);
        n_tests++;
        if (to || row_w[1] !== 6'd20 || col_w[1] !== 6'd0 || steps_w[1] !== 16'd25) begin
            n_fail++;
            $display("FAIL hand_left: got (%0d,%0d) steps=%0d timeout=%b want (20,0) 25",
                     row_w[1], col_w[1], steps_w[1], to);
        end
    endtask

    task automatic test_busy_ignore();
        int cyc1, cyc2; bit to;
        all_walls(); clr_log();
        for (int c = 10; c < 64; c++) maze[10][c] = 1'b0;
        kick(0, 6'd10, 6'd10, 2'd1);
        run(0, 10, cyc1, to);
        kick(0, 6'd10, 6'd30, 2'd1);
        run(0, 2000, cyc2, to);
        n_tests++;
        if (to || cyc1 + cyc2 != 267 || steps_w[0] !== 16'd53 || col_w[0] !== 6'd63) begin
            n_fail++;
            $display("FAIL busy_ignore: cyc=%0d steps=%0d col=%0d timeout=%b want 267 53 63",
                     cyc1 + cyc2, steps_w[0], col_w[0], to);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc; bit to;
        all_walls(); clr_log();
        for (int c = 10; c < 64; c++) maze[10][c] = 1'b0;
        kick(0, 6'd10, 6'd10, 2'd1);
        run(0, 20, cyc, to);
        // cycle 20 is the WAIT_F of the fourth move, probing (10,14)
        n_tests++;
        if (row_w[0] !== 6'd10 || col_w[0] !== 6'd14 || steps_w[0] !== 16'd3 || oe_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_state: got (%0d,%0d) steps=%0d oe=%b busy=%b want (10,14) 3 0 1",
                     row_w[0], col_w[0], steps_w[0], oe_w[0], busy_w[0]);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({row_w[0], col_w[0], oe_w[0], we_w[0], busy_w[0], done_w[0], fail_w[0], steps_w[0]} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got r=%0d c=%0d oe=%b we=%b busy=%b steps=%0d want all 0",
                     row_w[0], col_w[0], oe_w[0], we_w[0], busy_w[0], steps_w[0]);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (oe_w[0] !== 1'b0 || we_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: oe=%b we=%b busy=%b want 0 0 0", oe_w[0], we_w[0], busy_w[0]);
        end
    endtask

    task automatic test_no_overlap();
        n_tests++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL oe_we_overlap: got %0d cycles want 0", overlap);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_w[i] = 1'b0;
            rd_w[i]    = 1'b1;
        end
        all_walls();
        @(negedge clk);
        test_reset();
        test_border_start();
        test_corridor();
        test_dead_end();
        test_step_limit();
        test_hand();
        test_busy_ignore();
        test_reset_mid_run();
        test_no_overlap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
